npu_fifo_endpoint: RTL and testbench

NPU-side endpoint of the processor↔NPU FIFO interface. The processor pushes operand words into the input queue and configuration words into the config queue, then pops results from the output queue. The NPU core drains the input and config queues and fills the output queue over valid/ready streams. The block owns all three queues, their full/empty flags toward the processor, and sticky protocol-error status.

---
 rtl/npu_fifo_pkg.sv | 13 +
 rtl/npu_fifo_endpoint_if.sv | 36 +++
 rtl/npu_sync_fifo.sv | 43 ++++
 rtl/npu_fifo_endpoint.sv | 53 +++++
 tb/tb_npu_fifo_endpoint.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/npu_fifo_pkg.sv
// npu_fifo_pkg: shared width default, npu_err bit indices and a clog2 helper
package npu_fifo_pkg;
  localparam int DEFAULT_DATA_W = 32;
  localparam int ERR_IN_OVF = 0;
  localparam int ERR_CFG_OVF = 1;
  localparam int ERR_OUT_UNF = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/npu_fifo_endpoint_if.sv
// npu_fifo_endpoint_if: processor-side and core-side queue signals of the NPU endpoint
//   slave  = endpoint view (owns flags, heads, error status)
//   master = processor + NPU core view (drives strobes, pushes, readies)
interface npu_fifo_endpoint_if #(parameter int DATA_W = npu_fifo_pkg::DEFAULT_DATA_W);
  logic [DATA_W-1:0] npu_input_fifo;
  logic npu_input_fifo_we;
  logic npu_input_fifo_full;
  logic [DATA_W-1:0] npu_config_fifo;
  logic npu_config_fifo_we;
  logic npu_config_fifo_full;
  logic [DATA_W-1:0] npu_output_fifo;
  logic npu_output_fifo_re;
  logic npu_output_fifo_empty;
  logic [DATA_W-1:0] core_in_data;
  logic core_in_valid;
  logic core_in_ready;
  logic [DATA_W-1:0] core_cfg_data;
  logic core_cfg_valid;
  logic core_cfg_ready;
  logic [DATA_W-1:0] core_out_data;
  logic core_out_valid;
  logic core_out_ready;
  logic [2:0] npu_err;
  modport slave (
    input npu_input_fifo, npu_input_fifo_we, npu_config_fifo, npu_config_fifo_we,
          npu_output_fifo_re, core_in_ready, core_cfg_ready, core_out_data, core_out_valid,
    output npu_input_fifo_full, npu_config_fifo_full, npu_output_fifo, npu_output_fifo_empty,
           core_in_data, core_in_valid, core_cfg_data, core_cfg_valid, core_out_ready, npu_err
  );
  modport master (
    output npu_input_fifo, npu_input_fifo_we, npu_config_fifo, npu_config_fifo_we,
           npu_output_fifo_re, core_in_ready, core_cfg_ready, core_out_data, core_out_valid,
    input npu_input_fifo_full, npu_config_fifo_full, npu_output_fifo, npu_output_fifo_empty,
          core_in_data, core_in_valid, core_cfg_data, core_cfg_valid, core_out_ready, npu_err
  );
endinterface

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: circular-buffer FIFO with first-word fall-through head
//   push/din -> write side, pop/dout -> read side (dout is 0 while empty)
//   full/empty from registered pointers; push_rej/pop_rej flag refused requests
module npu_sync_fifo
  import npu_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic full,
  output logic empty,
  output logic push_rej,
  output logic pop_rej
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0] wrPtr, rdPtr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic pushOk, popOk;
  // extra MSB distinguishes full from empty when the low bits coincide
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty = wrPtr == rdPtr;
  assign pushOk = push && !full;
  assign popOk = pop && !empty;
  assign push_rej = push && full;
  assign pop_rej = pop && empty;
  assign dout = empty ? '0 : mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= pushOk ? wrPtr + (AW+1)'(1) : wrPtr;
      rdPtr <= popOk ? rdPtr + (AW+1)'(1) : rdPtr;
    end
  end
  always_ff @(posedge clk) if (pushOk) mem[wrPtr[AW-1:0]] <= din;
endmodule

// File: rtl/npu_fifo_endpoint.sv
// npu_fifo_endpoint: NPU-side endpoint owning input, config and output queues
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : processor push/pop side + core valid/ready side + sticky npu_err
module npu_fifo_endpoint
  import npu_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IN_DEPTH = 8,
  parameter int CFG_DEPTH = 8,
  parameter int OUT_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  npu_fifo_endpoint_if.slave bus
);
  logic inEmpty, cfgEmpty, outFull;
  logic inPushRej, cfgPushRej, outPopRej;
  logic [2:0] err;
  npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) inFifo (
    .clk(clk), .rst_n(rst_n),
    .push(bus.npu_input_fifo_we), .pop(bus.core_in_ready),
    .din(bus.npu_input_fifo), .dout(bus.core_in_data),
    .full(bus.npu_input_fifo_full), .empty(inEmpty),
    .push_rej(inPushRej), .pop_rej()
  );
  npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(CFG_DEPTH)) cfgFifo (
    .clk(clk), .rst_n(rst_n),
    .push(bus.npu_config_fifo_we), .pop(bus.core_cfg_ready),
    .din(bus.npu_config_fifo), .dout(bus.core_cfg_data),
    .full(bus.npu_config_fifo_full), .empty(cfgEmpty),
    .push_rej(cfgPushRej), .pop_rej()
  );
  // a refused core push is back-pressure, so only the processor pop side reports
  npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) outFifo (
    .clk(clk), .rst_n(rst_n),
    .push(bus.core_out_valid), .pop(bus.npu_output_fifo_re),
    .din(bus.core_out_data), .dout(bus.npu_output_fifo),
    .full(outFull), .empty(bus.npu_output_fifo_empty),
    .push_rej(), .pop_rej(outPopRej)
  );
  assign bus.core_in_valid = !inEmpty;
  assign bus.core_cfg_valid = !cfgEmpty;
  assign bus.core_out_ready = !outFull;
  assign bus.npu_err = err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= '0;
    else begin
      err[ERR_IN_OVF] <= err[ERR_IN_OVF] | inPushRej;
      err[ERR_CFG_OVF] <= err[ERR_CFG_OVF] | cfgPushRej;
      err[ERR_OUT_UNF] <= err[ERR_OUT_UNF] | outPopRej;
    end
  end
endmodule

// File: tb/tb_npu_fifo_endpoint.sv
// tb_npu_fifo_endpoint: directed self-checking bench for npu_fifo_endpoint
module tb_npu_fifo_endpoint;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  npu_fifo_endpoint_if #(.DATA_W(32)) b ();
  npu_fifo_endpoint #(.DATA_W(32), .IN_DEPTH(8), .CFG_DEPTH(8), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    b.npu_input_fifo = '0;
    b.npu_input_fifo_we = 1'b0;
    b.npu_config_fifo = '0;
    b.npu_config_fifo_we = 1'b0;
    b.npu_output_fifo_re = 1'b0;
    b.core_in_ready = 1'b0;
    b.core_cfg_ready = 1'b0;
    b.core_out_data = '0;
    b.core_out_valid = 1'b0;
    #12;
    chk("rst_in_full", 32'(b.npu_input_fifo_full), 0);
    chk("rst_cfg_full", 32'(b.npu_config_fifo_full), 0);
    chk("rst_out_empty", 32'(b.npu_output_fifo_empty), 1);
    chk("rst_in_valid", 32'(b.core_in_valid), 0);
    chk("rst_cfg_valid", 32'(b.core_cfg_valid), 0);
    chk("rst_out_ready", 32'(b.core_out_ready), 1);
    chk("rst_err", 32'(b.npu_err), 0);
    chk("rst_out_data", b.npu_output_fifo, 0);
    chk("rst_in_data", b.core_in_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    b.npu_input_fifo_we = 1'b1;
    b.npu_input_fifo = 32'h11111111;
    tick();
    chk("in_valid_1", 32'(b.core_in_valid), 1);
    chk("in_data_1", b.core_in_data, 32'h11111111);
    b.npu_input_fifo = 32'h22222222;
    tick();
    b.npu_input_fifo_we = 1'b0;
    chk("in_head_hold", b.core_in_data, 32'h11111111);
    b.core_in_ready = 1'b1;
    tick();
    chk("in_data_2", b.core_in_data, 32'h22222222);
    tick();
    b.core_in_ready = 1'b0;
    chk("in_empty_valid", 32'(b.core_in_valid), 0);
    chk("in_empty_data", b.core_in_data, 0);
    b.npu_config_fifo_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b.npu_config_fifo = 32'(i);
      tick();
      if (i == 6) chk("cfg_not_full_7", 32'(b.npu_config_fifo_full), 0);
    end
    chk("cfg_full_8", 32'(b.npu_config_fifo_full), 1);
    b.npu_config_fifo = 32'hDEAD;
    tick();
    b.npu_config_fifo_we = 1'b0;
    chk("cfg_ovf_err", 32'(b.npu_err), 32'b010);
    chk("cfg_still_full", 32'(b.npu_config_fifo_full), 1);
    b.core_cfg_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("cfg_drain", b.core_cfg_data, 32'(i));
      tick();
    end
    b.core_cfg_ready = 1'b0;
    chk("cfg_drained", 32'(b.core_cfg_valid), 0);
    b.core_out_valid = 1'b1;
    b.core_out_data = 32'hA5A5A5A5;
    tick();
    b.core_out_valid = 1'b0;
    chk("out_not_empty", 32'(b.npu_output_fifo_empty), 0);
    chk("out_head", b.npu_output_fifo, 32'hA5A5A5A5);
    b.npu_output_fifo_re = 1'b1;
    tick();
    chk("out_empty", 32'(b.npu_output_fifo_empty), 1);
    chk("out_zero", b.npu_output_fifo, 0);
    chk("out_err_keep", 32'(b.npu_err), 32'b010);
    tick();
    b.npu_output_fifo_re = 1'b0;
    chk("out_unf_err", 32'(b.npu_err), 32'b110);
    b.npu_input_fifo_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b.npu_input_fifo = 32'(100 + i);
      tick();
    end
    chk("in_full", 32'(b.npu_input_fifo_full), 1);
    b.npu_input_fifo = 32'hBEEF;
    b.core_in_ready = 1'b1;
    tick();
    b.npu_input_fifo_we = 1'b0;
    b.core_in_ready = 1'b0;
    chk("in_full_after_pp", 32'(b.npu_input_fifo_full), 0);
    chk("in_ovf_err", 32'(b.npu_err), 32'b111);
    b.core_in_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("in_drain", b.core_in_data, 32'(100 + i));
      tick();
    end
    b.core_in_ready = 1'b0;
    chk("in_no_beef", 32'(b.core_in_valid), 0);
    b.core_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.core_out_data = 32'(200 + i);
      tick();
    end
    b.npu_output_fifo_re = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b.core_out_data = 32'(204 + k);
      chk("wrap_head", b.npu_output_fifo, 32'(200 + k));
      tick();
      chk("wrap_not_empty", 32'(b.npu_output_fifo_empty), 0);
      chk("wrap_ready", 32'(b.core_out_ready), 1);
    end
    b.core_out_valid = 1'b0;
    for (int k = 20; k < 24; k++) begin
      chk("wrap_tail", b.npu_output_fifo, 32'(200 + k));
      tick();
    end
    b.npu_output_fifo_re = 1'b0;
    chk("wrap_empty", 32'(b.npu_output_fifo_empty), 1);
    b.npu_input_fifo_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b.npu_input_fifo = 32'(300 + i);
      tick();
    end
    b.npu_input_fifo_we = 1'b0;
    chk("pre_rst_valid", 32'(b.core_in_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_valid", 32'(b.core_in_valid), 0);
    chk("arst_in_data", b.core_in_data, 0);
    chk("arst_in_full", 32'(b.npu_input_fifo_full), 0);
    chk("arst_err", 32'(b.npu_err), 0);
    chk("arst_out_ready", 32'(b.core_out_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(b.core_in_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
